// File: rtl/dt_tree_walker_if.sv
// dt_tree_walker_if
//   Bundles the two downstream links of the tree walker:
//   - node memory read port: node_rd_en / node_rd_addr out, node_rd_data
//     back one cycle after node_rd_en (synchronous memory).
//   - comparator port: cmp_en / cmp_feature / cmp_threshold out,
//     cmp_go_left / cmp_done back.
//   Modports: master = walker side, slave = memory/comparator side.
//
// Comparator handshake: cmp_en acts as "valid" and cmp_done as "ready".
// The walker raises cmp_en with both operands and keeps cmp_en and the
// operands unchanged until the cycle in which cmp_done=1; that single
// cycle is the transfer, and cmp_go_left is consumed in it. cmp_en then
// drops for at least one cycle before the next request.
interface dt_tree_walker_if #(
  parameter int FEAT_IDX_W = 3,
  parameter int NODE_AW    = 8,
  parameter int CLASS_W    = 4
);
  localparam int NW = 1 + FEAT_IDX_W + 64 + 2*NODE_AW + CLASS_W;

  logic               node_rd_en;
  logic [NODE_AW-1:0] node_rd_addr;
  logic [NW-1:0]      node_rd_data;
  logic               cmp_en;
  logic [63:0]        cmp_feature;
  logic [63:0]        cmp_threshold;
  logic               cmp_go_left;
  logic               cmp_done;

  modport master (
    output node_rd_en, node_rd_addr, cmp_en, cmp_feature, cmp_threshold,
    input  node_rd_data, cmp_go_left, cmp_done
  );

  modport slave (
    input  node_rd_en, node_rd_addr, cmp_en, cmp_feature, cmp_threshold,
    output node_rd_data, cmp_go_left, cmp_done
  );
endinterface

// File: rtl/dt_tree_walker.sv
// dt_tree_walker
//   Decision-tree traversal engine. Holds NUM_FEATURES Q32.32 feature
//   registers, walks a tree held in a synchronous node memory starting
//   at ROOT_ADDR, uses an external comparator to choose left/right at
//   each internal node and reports the leaf class.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin traversal (sampled in IDLE only)
//   feat_wr_*           feature register write (ignored while busy)
//   bus (master)        node memory read port + comparator port
//   busy, done          busy FETCH..DONE, one-cycle done pulse
//   class_out, error    result of the last traversal, held until start
//   depth_out           comparisons made in the last traversal
//   path_out            (DT_PATH_TRACE_EN only) go_left bit per depth
//   state_dbg           current FSM state encoding
//
// Optional feature macro: DT_PATH_TRACE_EN (adds path_out).
//
// Node word, MSB..LSB: is_leaf, feat_idx, threshold[63:0], left_addr,
// right_addr, class.
module dt_tree_walker #(
  parameter int NUM_FEATURES = 8,
  parameter int FEAT_IDX_W   = 3,
  parameter int NODE_AW      = 8,
  parameter int CLASS_W      = 4,
  parameter int MAX_DEPTH    = 16,
  parameter int ROOT_ADDR    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  feat_wr_en,
  input  logic [FEAT_IDX_W-1:0] feat_wr_idx,
  input  logic [63:0]           feat_wr_data,
  dt_tree_walker_if.master      bus,
  output logic                  busy,
  output logic                  done,
  output logic [CLASS_W-1:0]    class_out,
  output logic [4:0]            depth_out,
  output logic                  error,
`ifdef DT_PATH_TRACE_EN
  output logic [MAX_DEPTH-1:0]  path_out,
`endif
  output logic [2:0]            state_dbg
);

  localparam int NW = 1 + FEAT_IDX_W + 64 + 2*NODE_AW + CLASS_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LOAD    = 3'd2,
    DECIDE  = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t             state;
  logic [NODE_AW-1:0] cur_addr;
  logic [NW-1:0]      node_q;
  logic [4:0]         depth;
  logic [63:0]        feature [NUM_FEATURES];

  // Field views of the registered node word.
  logic                  n_leaf;
  logic [FEAT_IDX_W-1:0] n_idx;
  logic [63:0]           n_thr;
  logic [NODE_AW-1:0]    n_left;
  logic [NODE_AW-1:0]    n_right;
  logic [CLASS_W-1:0]    n_class;
  logic                  n_bad_idx;

  assign n_class = node_q[CLASS_W-1:0];
  assign n_right = node_q[CLASS_W +: NODE_AW];
  assign n_left  = node_q[CLASS_W+NODE_AW +: NODE_AW];
  assign n_thr   = node_q[CLASS_W+2*NODE_AW +: 64];
  assign n_idx   = node_q[CLASS_W+2*NODE_AW+64 +: FEAT_IDX_W];
  assign n_leaf  = node_q[NW-1];

  // Widened by one bit so the range test stays meaningful whatever the
  // relation between NUM_FEATURES and 2^FEAT_IDX_W.
  assign n_bad_idx = {1'b0, n_idx} >= (FEAT_IDX_W+1)'(NUM_FEATURES);

  assign bus.node_rd_addr = cur_addr;
  assign state_dbg        = state;

  // Feature registers: writable only while idle; out-of-range indices
  // are dropped. A write coinciding with start lands before the first
  // COMPARE, so the traversal sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FEATURES; i++) feature[i] <= '0;
    end else if (feat_wr_en && !busy &&
                 ({1'b0, feat_wr_idx} < (FEAT_IDX_W+1)'(NUM_FEATURES))) begin
      feature[feat_wr_idx] <= feat_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cur_addr          <= '0;
      node_q            <= '0;
      depth             <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      class_out         <= '0;
      depth_out         <= '0;
      error             <= 1'b0;
      bus.node_rd_en    <= 1'b0;
      bus.cmp_en        <= 1'b0;
      bus.cmp_feature   <= '0;
      bus.cmp_threshold <= '0;
`ifdef DT_PATH_TRACE_EN
      path_out          <= '0;
`endif
    end else begin
      done           <= 1'b0;
      bus.node_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            depth          <= '0;
            error          <= 1'b0;
            class_out      <= '0;
            cur_addr       <= NODE_AW'(ROOT_ADDR);
            busy           <= 1'b1;
            bus.node_rd_en <= 1'b1;
`ifdef DT_PATH_TRACE_EN
            path_out       <= '0;
`endif
            state          <= FETCH;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          node_q <= bus.node_rd_data;
          state  <= DECIDE;
        end
        DECIDE: begin
          if (n_leaf) begin
            class_out <= n_class;
            depth_out <= depth;
            done      <= 1'b1;
            state     <= DONE;
          end else if (n_bad_idx || (depth == 5'(MAX_DEPTH))) begin
            error     <= 1'b1;
            class_out <= '0;
            depth_out <= depth;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            // Operands are captured once here and held for the whole stay.
            bus.cmp_en        <= 1'b1;
            bus.cmp_feature   <= feature[n_idx];
            bus.cmp_threshold <= n_thr;
            state             <= COMPARE;
          end
        end
        COMPARE: begin
          if (bus.cmp_done) begin
            cur_addr          <= bus.cmp_go_left ? n_left : n_right;
            depth             <= depth + 5'd1;
            bus.cmp_en        <= 1'b0;
            bus.cmp_feature   <= '0;
            bus.cmp_threshold <= '0;
            bus.node_rd_en    <= 1'b1;
`ifdef DT_PATH_TRACE_EN
            for (int d = 0; d < MAX_DEPTH; d++)
              if (depth == 5'(d)) path_out[d] <= bus.cmp_go_left;
`endif
            state             <= FETCH;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dt_tree_walker.md
Name: dt_tree_walker

Overview:
- Decision-tree traversal engine that sits directly downstream of the Q32.32 comparator and drives it.
- Holds a feature vector of Q32.32 values loaded from the CAN feature-extraction stage.
- Walks the tree from a root node. For each internal node it fetches the node word from a synchronous node memory, hands one feature and the node's threshold to the comparator, and follows the left or right child based on `go_left`.
- Stops at a leaf and reports the class.

Parameters:
- NUM_FEATURES, 8: number of 64-bit feature registers.
- FEAT_IDX_W, 3: feature index width; must satisfy 2^FEAT_IDX_W >= NUM_FEATURES.
- NODE_AW, 8: node memory address width.
- CLASS_W, 4: class label width.
- MAX_DEPTH, 16: maximum comparisons per traversal before abort.
- ROOT_ADDR, 0: node address where every traversal starts.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin traversal; sampled only in IDLE.
- feat_wr_en  in  1  feature register write strobe.
- feat_wr_idx  in  FEAT_IDX_W  feature register index.
- feat_wr_data  in  64  feature value, Q32.32 signed.
- node_rd_en  out  1  node memory read strobe.
- node_rd_addr  out  NODE_AW  node memory address.
- node_rd_data  in  NW  node word, valid the cycle after node_rd_en. NW = 1+FEAT_IDX_W+64+2*NODE_AW+CLASS_W (88 at defaults).
- cmp_en  out  1  comparator enable.
- cmp_feature  out  64  comparator feature operand.
- cmp_threshold  out  64  comparator threshold operand.
- cmp_go_left  in  1  comparator result (feature <= threshold, signed).
- cmp_done  in  1  comparator result valid.
- busy  out  1  high from FETCH through DONE inclusive.
- done  out  1  one-cycle completion pulse.
- class_out  out  CLASS_W  leaf class; holds until next start.
- depth_out  out  5  comparisons performed in the last traversal.
- error  out  1  last traversal aborted; holds until next start.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, feature registers 0, node register 0. Reset is asynchronous and may occur in any state. Assertion mid-traversal abandons it; no done pulse is produced.
- Node word fields, MSB to LSB: is_leaf, feat_idx, threshold[63:0], left_addr, right_addr, class.
- States: IDLE, FETCH, LOAD, DECIDE, COMPARE, DONE.
- IDLE: when start=1, clear depth, error, class_out and path state; cur_addr <= ROOT_ADDR; go to FETCH.
- FETCH: node_rd_en=1, node_rd_addr=cur_addr, cmp_en=0; go to LOAD.
- LOAD: register node_rd_data into node_q; go to DECIDE.
- DECIDE, evaluated in priority order:
  - is_leaf: class_out <= class; go to DONE.
  - feat_idx >= NUM_FEATURES, or depth == MAX_DEPTH: error <= 1; class_out <= 0; go to DONE.
  - otherwise: go to COMPARE.
- COMPARE:
  - cmp_en=1; cmp_feature=feature[feat_idx]; cmp_threshold=node_q.threshold. Both operands are stable for the whole COMPARE stay.
  - Wait for cmp_done=1. On that cycle: cur_addr <= cmp_go_left ? left_addr : right_addr; depth++; go to FETCH.
  - cmp_en is low in FETCH, which guarantees at least one idle cycle between comparisons.
  - No timeout; the comparator must eventually assert cmp_done.
- DONE: done=1 for exactly one cycle; depth_out <= depth; go to IDLE.
- Latency:
  - Leaf at root: done high in the 4th cycle after the edge that samples start.
  - Each internal node adds 3 + Lc cycles, where Lc = cycles in COMPARE (Lc=1 if cmp_done is already high in the first COMPARE cycle).
- start while busy: ignored.
- Feature writes:
  - Accepted only when busy=0; writes while busy are dropped.
  - A write with feat_wr_idx >= NUM_FEATURES is dropped.
  - A write and start in the same cycle: the write lands first, so the traversal sees the new value.
- cmp_feature and cmp_threshold drive 0 outside COMPARE.

Optional Feature:
- Macro: DT_PATH_TRACE_EN.
- Defined: adds output path_out [MAX_DEPTH-1:0].
  - Bit d = cmp_go_left taken at depth d.
  - Cleared on start; reset 0; holds after done.
  - Bits at depth >= depth_out read 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Root node is a leaf with class=5; pulse start -> done pulses in the 4th cycle; class_out=5, depth_out=0, error=0.
- feature[2]=1.5 (0x0000_0001_8000_0000); root: idx2, thr 2.0, left leaf class 3, right leaf class 7 -> class_out=3, depth_out=1; path_out[0]=1 when DT_PATH_TRACE_EN is defined.
- Same tree with feature[2]=2.5 -> class_out=7; then -2.0 vs thr -2.0 (equal) -> class_out=3.
- Chain of 17 non-leaf nodes each pointing to the next -> error=1, class_out=0, depth_out=16, exactly one done pulse.
- Comparator model delays cmp_done by 3 cycles -> cmp_en and operands stay stable until done; total latency = 4 + (3+4) cycles for the 1-compare tree.
- Assert rst_n=0 while in COMPARE -> all outputs 0 immediately; no done pulse. After release, start -> correct class; a feat_wr_en pulse while busy leaves the register unchanged.
